// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared types and constants for the RV32M multiply/divide sequencer.
// Holds the funct3 op encodings, the 3-bit FSM state encoding and a latency helper.
package mdu_sequencer_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MDU_STATE_IDLE  = 3'd0,
    MDU_STATE_MUL   = 3'd1,
    MDU_STATE_DIV   = 3'd2,
    MDU_STATE_FIXUP = 3'd3,
    MDU_STATE_DONE  = 3'd4
  } mdu_state_t;

  // Start-to-done latency of an iterative operation
  function automatic int unsigned mdu_latency(input int unsigned xlen);
    return xlen + 2;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
// Ports: rem_i/rem_o partial remainder (XLEN+1), quo_i/quo_o dividend/quotient
// shift register (XLEN), div_i divisor magnitude (XLEN).
module mdu_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  // Trial subtract one bit wider than the remainder so the MSB is the borrow
  logic [XLEN+1:0] trial;

  always_comb begin
    trial = {rem_i, quo_i[XLEN-1]} - {2'b00, div_i};
    rem_o = trial[XLEN+1] ? {rem_i[XLEN-1:0], quo_i[XLEN-1]} : trial[XLEN:0];
    quo_o = {quo_i[XLEN-2:0], ~trial[XLEN+1]};
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Iterative shift-add multiply / restoring divide on magnitudes, then sign fix-up.
// Ports: i_clk, i_rst (async, active-high), i_start, i_funct3, i_a, i_b, i_flush;
//        o_busy (state != IDLE), o_done (1-cycle pulse), o_result (held until next start).
// Option: define MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
// XLEN must be >= 8 and a power of two.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_a_q, neg_a_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q;

  // Operand decode at accept
  logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (i_funct3 == MDU_OP_MUL) || (i_funct3 == MDU_OP_MULH) ||
               (i_funct3 == MDU_OP_MULHSU) || (i_funct3 == MDU_OP_DIV) ||
               (i_funct3 == MDU_OP_REM);
    b_signed = (i_funct3 == MDU_OP_MUL) || (i_funct3 == MDU_OP_MULH) ||
               (i_funct3 == MDU_OP_DIV) || (i_funct3 == MDU_OP_REM);
    sa       = a_signed & i_a[XLEN-1];
    sb       = b_signed & i_b[XLEN-1];
    a_mag    = sa ? (~i_a + XLEN'(1)) : i_a;
    b_mag    = sb ? (~i_b + XLEN'(1)) : i_b;
    div_zero = i_funct3[2] && (i_b == '0);
    div_ovf  = i_funct3[2] && b_signed && (i_a == SMIN) && (i_b == '1);
  end

  // One shift-add multiply step: conditionally add multiplicand to the high half, shift right
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Divide step; quotient lives in the low half of the accumulator
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i (rem_q),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (opb_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  // Sign fix-up of the magnitude results
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];
  end

`ifdef MDU_FAST_MUL_EN
  // Sign/zero-extended signed product; the low 2*XLEN bits equal the (XLEN+1)x(XLEN+1) result
  logic signed [AW-1:0] fast_a, fast_b;
  logic        [AW-1:0] fast_p;

  always_comb begin
    fast_a = {{XLEN{sa}}, i_a};
    fast_b = {{XLEN{sb}}, i_b};
    fast_p = fast_a * fast_b;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      MDU_STATE_IDLE: begin
        if (i_start && !i_flush) begin
          op_d      = i_funct3;
          neg_res_d = sa ^ sb;
          neg_a_d   = sa;
          cnt_d     = CW'(XLEN - 1);
          if (div_zero) begin
            result_d = i_funct3[1] ? i_a : '1;
            done_d   = 1'b1;
            state_d  = MDU_STATE_DONE;
          end else if (div_ovf) begin
            result_d = i_funct3[1] ? '0 : i_a;
            done_d   = 1'b1;
            state_d  = MDU_STATE_DONE;
          end else if (i_funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            rem_d   = '0;
            opb_d   = b_mag;
            state_d = MDU_STATE_DIV;
          end else begin
`ifdef MDU_FAST_MUL_EN
            result_d = (i_funct3 == MDU_OP_MUL) ? fast_p[XLEN-1:0] : fast_p[AW-1:XLEN];
            done_d   = 1'b1;
            state_d  = MDU_STATE_DONE;
`else
            acc_d   = {{XLEN{1'b0}}, b_mag};
            opb_d   = a_mag;
            state_d = MDU_STATE_MUL;
`endif
          end
        end
      end
      MDU_STATE_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = MDU_STATE_FIXUP;
      end
      MDU_STATE_DIV: begin
        acc_d = {acc_q[AW-1:XLEN], quo_nxt};
        rem_d = rem_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = MDU_STATE_FIXUP;
      end
      MDU_STATE_FIXUP: begin
        if (op_q[2]) result_d = op_q[1] ? rem_fix : quo_fix;
        else result_d = (op_q == MDU_OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[AW-1:XLEN];
        done_d  = 1'b1;
        state_d = MDU_STATE_DONE;
      end
      MDU_STATE_DONE: state_d = MDU_STATE_IDLE;
      default:        state_d = MDU_STATE_IDLE;
    endcase

    // Abort drops the op without a done pulse and keeps the previous result
    if (i_flush && (state_q != MDU_STATE_IDLE)) begin
      state_d  = MDU_STATE_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= MDU_STATE_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= (state_d != MDU_STATE_IDLE);
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed + short random self-checking bench for mdu_sequencer.
// Expected results/latencies are queued at start and popped when o_done fires.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_a, i_b;
  logic        i_flush;
  logic        o_busy, o_done;
  logic [31:0] o_result;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] sb_res[$];
  int          sb_lat[$];
  logic [31:0] last_exp;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_funct3 (i_funct3),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model on 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic        [63:0] p;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    qa = a;
    qb = b;
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return a;
        return qa / qb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        return qa % qb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == SMIN && b == 32'hFFFF_FFFF) return 1;
      return int'(mdu_latency(XLEN));
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return int'(mdu_latency(XLEN));
`endif
  endfunction

  // Launch one op, wait (bounded) for done, then compare against the scoreboard
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int lat, busy_n, want_lat;
    bit got;
    logic [31:0] want;
    sb_res.push_back(exp);
    sb_lat.push_back(exp_lat(f3, a, b));
    @(negedge i_clk);
    i_start = 1'b1; i_funct3 = f3; i_a = a; i_b = b;
    lat = 0; busy_n = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge i_clk);
      lat++;
      if (!hold) i_start = 1'b0;
      if (o_busy) busy_n++;
      if (o_done) got = 1'b1;
    end
    // Cycle after DONE: a held start in DONE must have been ignored
    @(negedge i_clk);
    i_start = 1'b0;
    want     = sb_res.pop_front();
    want_lat = sb_lat.pop_front();
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " result"}, o_result, want);
    check({tag, " latency"}, 32'(lat), 32'(want_lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(want_lat));
    check({tag, " done_pulse"}, 32'(o_done), 32'd0);
    check({tag, " idle_after"}, 32'(o_busy), 32'd0);
    last_exp = want;
  endtask

  initial begin
    int dones;
    logic [2:0] rf3;
    logic [31:0] ra, rb;
    i_rst = 1'b1; i_start = 1'b0; i_funct3 = '0; i_a = '0; i_b = '0; i_flush = 1'b0;
    last_exp = '0;
    repeat (2) @(negedge i_clk);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst result", o_result, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("MULH min*min", 3'd1, SMIN, SMIN, 32'h4000_0000, 1'b0);
    run_op("MULHU min*min", 3'd3, SMIN, SMIN, 32'h4000_0000, 1'b0);
    run_op("MULHSU -1*ffffffff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV -20/3", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0);
    run_op("REM -20%3", 3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("REMU 100%7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("DIVU by0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("REMU by0", 3'd7, 32'h1234, 32'd0, 32'h0000_1234, 1'b0);
    run_op("DIV ovf", 3'd4, SMIN, 32'hFFFF_FFFF, SMIN, 1'b0);
    run_op("REM ovf", 3'd6, SMIN, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("DIV 7/-2", 3'd4, 32'd7, 32'hFFFF_FFFE, ref_mdu(3'd4, 32'd7, 32'hFFFF_FFFE), 1'b0);
    run_op("REM 7%-2", 3'd6, 32'd7, 32'hFFFF_FFFE, ref_mdu(3'd6, 32'd7, 32'hFFFF_FFFE), 1'b0);

    // Start held high through busy and DONE: exactly one op executes
    run_op("MULHU held", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678,
           ref_mdu(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), 1'b1);
    @(negedge i_clk);
    check("held no_restart", 32'(o_busy), 32'd0);

    // Flush priority over start in IDLE
    @(negedge i_clk);
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd5; i_a = 32'd50; i_b = 32'd5;
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    check("idle flush no_accept", 32'(o_busy), 32'd0);

    // Flush mid-divide at T+10
    i_start = 1'b1; i_funct3 = 3'd4; i_a = 32'd1000; i_b = 32'd7;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_done) dones++;
    end
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    if (o_done) dones++;
    check("flush busy", 32'(o_busy), 32'd0);
    check("flush no_done", 32'(dones), 32'd0);
    check("flush result_kept", o_result, last_exp);
    run_op("MUL after flush", 3'd0, 32'h0001_0003, 32'hFFFF_0005,
           ref_mdu(3'd0, 32'h0001_0003, 32'hFFFF_0005), 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op("random", rf3, ra, rb, ref_mdu(rf3, ra, rb), 1'b0);
    end

    // Async reset mid-divide
    @(negedge i_clk);
    i_start = 1'b1; i_funct3 = 3'd4; i_a = 32'd12345; i_b = 32'd11;
    repeat (5) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    i_rst = 1'b1;
    #1;
    check("midrst busy", 32'(o_busy), 32'd0);
    check("midrst done", 32'(o_done), 32'd0);
    check("midrst result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_done) dones++;
    end
    check("midrst no_done", 32'(dones), 32'd0);
    check("midrst idle", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide unit, sitting in the execute stage beside the single-cycle ALU.
- Accepts one M-extension operation (selected by funct3), iterates a shift-add multiplier or a restoring divider over XLEN cycles, then applies sign fix-up.
- Returns a registered result with a one-cycle done pulse.
- Pipeline control uses o_busy to stall EX while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_a  in  XLEN  rs1 operand.
- i_b  in  XLEN  rs2 operand.
- i_flush  in  1  abort the in-flight op (branch mispredict or trap).
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse; o_result valid in that cycle.
- o_result  out  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE, o_busy=0, o_done=0, o_result=0, counter=0, all internal accumulators=0.
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- States and transitions:
  - IDLE -> MUL or DIV when i_start=1.
  - MUL/DIV -> FIXUP when counter reaches 0.
  - FIXUP -> DONE.
  - DONE -> IDLE unconditionally.
- Accept (cycle T, IDLE, i_start=1):
  - Latch funct3 and operand signs.
  - Latch magnitudes: |a| and |b| for signed operands; MULHSU takes |a| only.
  - Set counter=XLEN-1.
- Iteration:
  - Each MUL/DIV cycle retires one bit: shift-add for multiply, restoring subtract for divide.
  - Counter decrements each cycle; iterations occupy T+1..T+XLEN.
- FIXUP (T+XLEN+1):
  - Negate the product if the operand signs differ (signed ops).
  - Negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Select low half (MUL) or high half (MULH*) of the 2*XLEN product.
- DONE (T+XLEN+2): o_done=1 and o_result registered. Normal latency is start-to-done XLEN+2 cycles.
- Divide by zero, detected at accept: go IDLE -> DONE directly, so o_done is at T+1.
  - DIV/DIVU: result = all ones.
  - REM/REMU: result = i_a.
- Signed overflow (DIV/REM with a = -2^(XLEN-1), b = -1): DONE at T+1.
  - DIV: result = a.
  - REM: result = 0.
- i_start while busy: ignored; no queuing.
- i_start in the DONE cycle: ignored. The earliest back-to-back start is the cycle after DONE.
- i_flush:
  - In any non-IDLE state, the next state is IDLE, o_done is not asserted, and o_result is unchanged.
  - i_flush has priority over i_start in IDLE; a start is not accepted in a cycle with i_flush=1.
- Arithmetic:
  - The multiply accumulator is 2*XLEN bits; all adds are unsigned on magnitudes.
  - The divider remainder register is XLEN+1 bits to hold the trial-subtract borrow.
  - MULHU/DIVU/REMU skip all sign handling.
- Reset mid-operation: the async clear wins immediately; no done pulse.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MUL* ops use a combinational (XLEN+1)x(XLEN+1) signed product on sign/zero-extended operands.
  - Path is IDLE -> DONE, with o_done at T+1; the MUL state is unused.
  - Divide behaviour is unchanged.
- Undefined: the iterative shift-add path applies, with latency XLEN+2.

Decomposition:
- Shared header (types.vh):
  - `MDU_OP_MUL..`MDU_OP_REMU funct3 constants.
  - `MDU_STATE_IDLE/MUL/DIV/FIXUP/DONE` 3-bit encodings.
  - `MDU_LATENCY` = XLEN+2.
- One sub-module, mdu_div_step: combinational restoring step taking {rem, quo, divisor} and returning the next {rem, quo}; reused by any future radix-4 variant.

Test Plan:
- MUL a=7, b=-3 -> o_result=0xFFFFFFEB; o_done exactly at T+34 (T+1 with MDU_FAST_MUL_EN); o_busy high T+1..T+34.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> quotient 0xFFFFFFFA; REM same operands -> 0xFFFFFFFE; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU/REMU a=0x1234, b=0 -> 0xFFFFFFFF / 0x1234 at T+1; DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0 at T+1.
- Start DIV, assert i_flush at T+10 -> IDLE at T+11, no o_done, o_result retains its prior value; a new MUL started at T+12 completes correctly.
- Pulse i_rst at T+5 of a DIV -> o_busy=0, o_done=0, o_result=0 immediately; i_start held during busy and during DONE -> only one op executes.
